// File: rtl/lsu_wb.sv
// lsu_wb: multi-cycle load/store unit driving the GPR write port from memory responses.
// Optional `LSU_MISALIGN_EXC_EN adds an accept-time alignment check and the misalign_o pulse.
module lsu_wb #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int RADDR_W = 5
) (
    input  logic               lsu_clk_i,
    input  logic               lsu_rst_i,
    input  logic               ex_valid_i,
    output logic               ex_ready_o,
    input  logic [3:0]         ex_op_i,
    input  logic [ADDR_W-1:0]  ex_addr_i,
    input  logic [DATA_W-1:0]  ex_wdata_i,
    input  logic [RADDR_W-1:0] ex_rd_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    output logic [7:0]         mem_wstrb_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [DATA_W-1:0]  mem_rdata_i,
    output logic               reg_wen_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0]  reg_wdata_o,
    output logic               lsu_done_o,
    output logic               lsu_busy_o,
    output logic [2:0]         lsu_state_o
`ifdef LSU_MISALIGN_EXC_EN
    ,
    output logic               misalign_o
`endif
);

    // Handshake: an op transfers on the rising edge where ex_valid_i & ex_ready_o;
    // a memory request transfers on the edge where mem_req_o & mem_gnt_i.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q;
    logic [3:0]         op_q;
    logic [2:0]         off_q;
    logic [RADDR_W-1:0] rd_q;

    logic               acc_ok;
    logic               acc_store;
    logic [7:0]         acc_base;
    logic [7:0]         acc_mask;
    logic [DATA_W-1:0]  acc_wdata;
`ifdef LSU_MISALIGN_EXC_EN
    logic               acc_misalign;
`endif

    assign lsu_state_o = state_q;

    function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] op,
                                                      input logic [2:0] off,
                                                      input logic [DATA_W-1:0] rdata);
        logic [DATA_W-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (op[1:0])
            2'b00:   load_extend = op[2] ? {{(DATA_W-8){1'b0}}, sh[7:0]}
                                         : {{(DATA_W-8){sh[7]}}, sh[7:0]};
            2'b01:   load_extend = op[2] ? {{(DATA_W-16){1'b0}}, sh[15:0]}
                                         : {{(DATA_W-16){sh[15]}}, sh[15:0]};
            2'b10:   load_extend = op[2] ? {{(DATA_W-32){1'b0}}, sh[31:0]}
                                         : {{(DATA_W-32){sh[31]}}, sh[31:0]};
            default: load_extend = sh;
        endcase
    endfunction

    always_comb begin
        acc_ok    = 1'b0;
        acc_store = ex_op_i[3];
        acc_base  = 8'h00;
        case (ex_op_i)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110,
            4'b1000, 4'b1001, 4'b1010, 4'b1011: acc_ok = 1'b1;
            default:                            acc_ok = 1'b0;
        endcase
        case (ex_op_i[1:0])
            2'b00:   acc_base = 8'h01;
            2'b01:   acc_base = 8'h03;
            2'b10:   acc_base = 8'h0F;
            default: acc_base = 8'hFF;
        endcase
        // 8-bit shift deliberately drops lanes past byte 7 for misaligned accesses.
        acc_mask  = acc_store ? (acc_base << ex_addr_i[2:0]) : 8'h00;
        acc_wdata = acc_store ? (ex_wdata_i << {ex_addr_i[2:0], 3'b000}) : '0;
`ifdef LSU_MISALIGN_EXC_EN
        case (ex_op_i[1:0])
            2'b01:   acc_misalign = ex_addr_i[0];
            2'b10:   acc_misalign = |ex_addr_i[1:0];
            2'b11:   acc_misalign = |ex_addr_i[2:0];
            default: acc_misalign = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge lsu_clk_i or posedge lsu_rst_i) begin
        if (lsu_rst_i) begin
            state_q     <= IDLE;
            op_q        <= '0;
            off_q       <= '0;
            rd_q        <= '0;
            ex_ready_o  <= 1'b1;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
            lsu_done_o  <= 1'b0;
            lsu_busy_o  <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
            misalign_o  <= 1'b0;
`endif
        end else begin
            lsu_done_o  <= 1'b0;
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
`ifdef LSU_MISALIGN_EXC_EN
            misalign_o  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (ex_valid_i && ex_ready_o) begin
                        op_q       <= ex_op_i;
                        off_q      <= ex_addr_i[2:0];
                        rd_q       <= ex_rd_i;
                        ex_ready_o <= 1'b0;
                        lsu_busy_o <= 1'b1;
                        if (!acc_ok) begin
                            state_q    <= DONE;
                            lsu_done_o <= 1'b1;
`ifdef LSU_MISALIGN_EXC_EN
                        end else if (acc_misalign) begin
                            state_q    <= DONE;
                            lsu_done_o <= 1'b1;
                            misalign_o <= 1'b1;
`endif
                        end else begin
                            state_q     <= REQ;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= acc_store;
                            mem_addr_o  <= {ex_addr_i[ADDR_W-1:3], 3'b000};
                            mem_wdata_o <= acc_wdata;
                            mem_wstrb_o <= acc_mask;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= '0;
                        mem_wstrb_o <= '0;
                        if (op_q[3]) begin
                            state_q    <= DONE;
                            lsu_done_o <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q     <= WB;
                        reg_wen_o   <= (rd_q != '0);
                        reg_waddr_o <= rd_q;
                        reg_wdata_o <= load_extend(op_q[2:0], off_q, mem_rdata_i);
                        lsu_done_o  <= 1'b1;
                    end
                end
                WB, DONE: begin
                    state_q    <= IDLE;
                    ex_ready_o <= 1'b1;
                    lsu_busy_o <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    ex_ready_o <= 1'b1;
                    lsu_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_wb.sv
// tb_lsu_wb: directed bench for lsu_wb with a GPR-write scoreboard.
module tb_lsu_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op;
    logic [63:0] ex_addr;
    logic [63:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [63:0] reg_wdata;
    logic        lsu_done;
    logic        lsu_busy;
    logic [2:0]  lsu_state;
`ifdef LSU_MISALIGN_EXC_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;
    logic [68:0] exp_q[$];

    lsu_wb dut (
        .lsu_clk_i   (clk),
        .lsu_rst_i   (rst),
        .ex_valid_i  (ex_valid),
        .ex_ready_o  (ex_ready),
        .ex_op_i     (ex_op),
        .ex_addr_i   (ex_addr),
        .ex_wdata_i  (ex_wdata),
        .ex_rd_i     (ex_rd),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wstrb_o (mem_wstrb),
        .mem_gnt_i   (mem_gnt),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i (mem_rdata),
        .reg_wen_o   (reg_wen),
        .reg_waddr_o (reg_waddr),
        .reg_wdata_o (reg_wdata),
        .lsu_done_o  (lsu_done),
        .lsu_busy_o  (lsu_busy),
        .lsu_state_o (lsu_state)
`ifdef LSU_MISALIGN_EXC_EN
        ,
        .misalign_o  (misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every GPR write must match the oldest expected {rd, data}.
    always @(negedge clk) begin
        if (!rst && reg_wen) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", reg_wen, 64'd0);
            end else begin
                logic [68:0] e;
                e = exp_q.pop_front();
                check("sb_waddr", reg_waddr, e[68:64]);
                check("sb_wdata", reg_wdata, e[63:0]);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [4:0] rd);
        ex_valid = 1'b1;
        ex_op    = op;
        ex_addr  = addr;
        ex_wdata = wdata;
        ex_rd    = rd;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [3:0] op, input logic [63:0] addr,
                           input logic [4:0] rd, input logic [63:0] rdata,
                           input int gnt_dly, input int rv_dly, input logic [63:0] exp_data);
        issue(op, addr, 64'h0, rd);
        for (int i = 0; i < gnt_dly; i++) begin
            check({tag, "_req_hold"}, mem_req, 1);
            tick();
        end
        check({tag, "_req"}, mem_req, 1);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, addr & ~64'h7);
        check({tag, "_ready_busy"}, ex_ready, 0);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check({tag, "_state_wait"}, lsu_state, 3'd2);
        check({tag, "_no_early_wb"}, reg_wen, 0);
        for (int i = 0; i < rv_dly; i++) begin
            check({tag, "_wait_done"}, lsu_done, 0);
            tick();
        end
        if (rd != 5'd0) exp_q.push_back({rd, exp_data});
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        check({tag, "_wen"}, reg_wen, rd != 5'd0);
        check({tag, "_waddr"}, reg_waddr, rd);
        check({tag, "_wdata"}, reg_wdata, exp_data);
        check({tag, "_done"}, lsu_done, 1);
        tick();
        check({tag, "_done_clr"}, lsu_done, 0);
        check({tag, "_wen_clr"}, reg_wen, 0);
        check({tag, "_ready"}, ex_ready, 1);
    endtask

    task automatic do_store(input string tag, input logic [3:0] op, input logic [63:0] addr,
                            input logic [63:0] wdata, input int gnt_dly,
                            input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                            input logic [7:0] exp_strb);
        issue(op, addr, wdata, 5'd1);
        for (int i = 0; i <= gnt_dly; i++) begin
            check({tag, "_req"}, mem_req, 1);
            check({tag, "_we"}, mem_we, 1);
            check({tag, "_addr"}, mem_addr, exp_addr);
            check({tag, "_wdata"}, mem_wdata, exp_wdata);
            check({tag, "_strb"}, mem_wstrb, exp_strb);
            check({tag, "_early_done"}, lsu_done, 0);
            if (i == gnt_dly) mem_gnt = 1'b1;
            tick();
        end
        mem_gnt = 1'b0;
        check({tag, "_done"}, lsu_done, 1);
        check({tag, "_req_clr"}, mem_req, 0);
        check({tag, "_state_done"}, lsu_state, 3'd4);
        check({tag, "_wen"}, reg_wen, 0);
        tick();
        check({tag, "_done_clr"}, lsu_done, 0);
        check({tag, "_ready"}, ex_ready, 1);
    endtask

    initial begin
        rst        = 1'b1;
        ex_valid   = 1'b0;
        ex_op      = 4'h0;
        ex_addr    = 64'h0;
        ex_wdata   = 64'h0;
        ex_rd      = 5'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ex_ready, 1);
        check("rst_req", mem_req, 0);
        check("rst_wen", reg_wen, 0);
        check("rst_done", lsu_done, 0);
        check("rst_busy", lsu_busy, 0);
        check("rst_state", lsu_state, 3'd0);
        rst = 1'b0;
        tick();

        do_load("lb",  4'b0000, 64'h8000_0003, 5'd5, 64'h0000_0000_8000_0000, 0, 0,
                64'hFFFF_FFFF_FFFF_FF80);
        do_load("lhu", 4'b0101, 64'h8000_0006, 5'd7, 64'hBEEF_0000_0000_0000, 0, 1,
                64'h0000_0000_0000_BEEF);
        do_load("lh",  4'b0001, 64'h8000_0002, 5'd8, 64'h0000_0000_F00D_0000, 1, 0,
                64'hFFFF_FFFF_FFFF_F00D);
        do_load("lw",  4'b0010, 64'h8000_0004, 5'd3, 64'h8765_4321_0000_0000, 0, 0,
                64'hFFFF_FFFF_8765_4321);
        do_load("lwu", 4'b0110, 64'h8000_0004, 5'd4, 64'h8765_4321_0000_0000, 0, 2,
                64'h0000_0000_8765_4321);
        do_load("lbu", 4'b0100, 64'h8000_0001, 5'd31, 64'h0000_0000_0000_9A00, 0, 0,
                64'h0000_0000_0000_009A);

        do_store("sw", 4'b1010, 64'h8000_0004, 64'h0000_0000_1234_5678, 3,
                 64'h8000_0000, 64'h1234_5678_0000_0000, 8'hF0);
        do_store("sb", 4'b1000, 64'h8000_0007, 64'h0000_0000_0000_00AB, 0,
                 64'h8000_0000, 64'hAB00_0000_0000_0000, 8'h80);
        do_store("sd", 4'b1011, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 1,
                 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF);
`ifndef LSU_MISALIGN_EXC_EN
        do_store("sh_mis", 4'b1001, 64'h8000_0007, 64'h0000_0000_0000_BEEF, 0,
                 64'h8000_0000, 64'hEF00_0000_0000_0000, 8'h80);
`endif

        // LD to x0 with ex_valid held across the whole op.
        ex_valid = 1'b1;
        ex_op    = 4'b0011;
        ex_addr  = 64'h8000_0008;
        ex_rd    = 5'd0;
        tick();
        check("ld0_req", mem_req, 1);
        check("ld0_ready_req", ex_ready, 0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ld0_ready_wait", ex_ready, 0);
            check("ld0_req_wait", mem_req, 0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1111_2222_3333_4444;
        tick();
        mem_rvalid = 1'b0;
        check("ld0_wen", reg_wen, 0);
        check("ld0_done", lsu_done, 1);
        check("ld0_ready_wb", ex_ready, 0);
        tick();
        check("ld0_ready_idle", ex_ready, 1);
        check("ld0_busy_idle", lsu_busy, 0);
        check("ld0_no_req_idle", mem_req, 0);
        tick();
        ex_valid = 1'b0;
        check("ld0_reaccept_req", mem_req, 1);
        check("ld0_reaccept_busy", lsu_busy, 1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check("ld0_second_done", lsu_done, 1);
        tick();

        // Undefined op code completes without touching memory.
        issue(4'b0111, 64'h8000_0000, 64'h0, 5'd6);
        check("undef_req", mem_req, 0);
        check("undef_done", lsu_done, 1);
        check("undef_state", lsu_state, 3'd4);
        tick();
        check("undef_ready", ex_ready, 1);

        // Asynchronous reset while waiting for the response.
        issue(4'b0010, 64'h8000_0000, 64'h0, 5'd9);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("arst_pre_state", lsu_state, 3'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", ex_ready, 1);
        check("arst_busy", lsu_busy, 0);
        check("arst_state", lsu_state, 3'd0);
        check("arst_req", mem_req, 0);
        #3;
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h5555_6666_7777_8888;
        tick();
        mem_rvalid = 1'b0;
        check("arst_no_wen", reg_wen, 0);
        check("arst_no_done", lsu_done, 0);
        tick();
        check("arst_no_wen2", reg_wen, 0);

`ifdef LSU_MISALIGN_EXC_EN
        issue(4'b0010, 64'h8000_0002, 64'h0, 5'd10);
        check("mis_req", mem_req, 0);
        check("mis_done", lsu_done, 1);
        check("mis_flag", misalign, 1);
        tick();
        check("mis_flag_clr", misalign, 0);
        check("mis_ready", ex_ready, 1);
`endif

        check("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_wb.md
Name:
lsu_wb

Overview:
- Multi-cycle load/store unit plus writeback driver for the 64-bit single-cycle-derived core.
- Takes one memory op from the execute stage and runs a req/grant/response handshake with data memory.
- For loads, aligns and extends the returned data, then drives the register file write port.
- Sits directly upstream of the register file write port (wen/waddr/wdata).

Parameters:
DATA_W, 64, GPR and memory data width
ADDR_W, 64, address width
RADDR_W, 5, GPR index width

Ports:
lsu_clk_i  in  1  clock
lsu_rst_i  in  1  reset, asynchronous, active-high
ex_valid_i  in  1  execute stage presents an op
ex_ready_o  out  1  unit can accept an op
ex_op_i  in  4  0000 LB, 0001 LH, 0010 LW, 0011 LD, 0100 LBU, 0101 LHU, 0110 LWU, 1000 SB, 1001 SH, 1010 SW, 1011 SD
ex_addr_i  in  ADDR_W  byte address
ex_wdata_i  in  DATA_W  store data, right-justified
ex_rd_i  in  RADDR_W  load destination GPR
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = store
mem_addr_o  out  ADDR_W  address with low 3 bits forced to 0
mem_wdata_o  out  DATA_W  store data shifted to its byte lane
mem_wstrb_o  out  8  byte enables
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  load data valid
mem_rdata_i  in  DATA_W  aligned doubleword
reg_wen_o  out  1  GPR write enable
reg_waddr_o  out  RADDR_W  GPR write index
reg_wdata_o  out  DATA_W  GPR write data
lsu_done_o  out  1  one-cycle completion pulse
lsu_busy_o  out  1  unit not in IDLE

Behaviour:
- Reset: all outputs 0 except ex_ready_o = 1; FSM goes to IDLE. Reset asserted mid-op abandons the op with no GPR write and no done pulse.
- FSM states: IDLE, REQ, WAIT, WB, DONE.
- IDLE:
  - ex_ready_o = 1.
  - On ex_valid_i & ex_ready_o, latch op, addr, wdata and rd, then go to REQ.
  - An undefined op code goes to DONE with no memory access.
- REQ:
  - mem_req_o = 1, and mem_we_o, mem_addr_o, mem_wdata_o and mem_wstrb_o are held stable until mem_gnt_i.
  - On grant: a store goes to DONE; a load goes to WAIT.
- WAIT: waits any number of cycles for mem_rvalid_i. mem_rvalid_i is ignored outside WAIT, so a response in the grant cycle is not accepted.
- WB:
  - Data is taken from mem_rdata_i at byte offset addr[2:0], then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to 64 bits.
  - Asserts reg_wen_o, reg_waddr_o = rd and reg_wdata_o for exactly one cycle, plus lsu_done_o, then returns to IDLE.
  - When rd = 0, reg_wen_o stays 0 but lsu_done_o still pulses.
- DONE: lsu_done_o = 1 for one cycle, then IDLE.
- ex_ready_o = 0 in every state except IDLE, so there is no back-to-back overlap.
- Store strobes:
  - Byte/half/word/double masks are 0x01, 0x03, 0x0F and 0xFF.
  - The mask is shifted left by addr[2:0]; bits shifted past 7 are dropped.
  - mem_wdata_o = wdata shifted left by 8 × addr[2:0].
- Minimum latency:
  - Load: accept at cycle 0, grant at cycle 1, rvalid at cycle 2, write at cycle 3.
  - Store: done at cycle 2.
- reg_wen_o is 0 in every state except WB.

Optional Feature:
LSU_MISALIGN_EXC_EN:
- Defined:
  - Accept-time check flags a misaligned op: half with addr[0] ≠ 0, word with addr[1:0] ≠ 0, double with addr[2:0] ≠ 0.
  - A misaligned op goes straight to DONE with no memory request and no GPR write.
  - Extra output misalign_o (1 bit) pulses together with lsu_done_o; it resets to 0.
- Undefined: no check and no misalign_o port. A misaligned access proceeds with truncated strobes as described above.

Test Plan:
- LB, addr 0x8000_0003, rd = 5, mem_rdata_i = 0x0000_0000_8000_0000 with gnt at cycle 1 and rvalid at cycle 2 -> cycle 3: reg_wen_o = 1, reg_waddr_o = 5, reg_wdata_o = 0xFFFF_FFFF_FFFF_FF80, lsu_done_o = 1.
- LHU, addr 0x8000_0006, mem_rdata_i = 0xBEEF_0000_0000_0000 -> reg_wdata_o = 0x0000_0000_0000_BEEF.
- SW, addr 0x8000_0004, wdata 0x1234_5678, gnt held low for 3 cycles -> mem_req_o and all request fields stable for 4 cycles, mem_addr_o = 0x8000_0000, mem_wstrb_o = 0xF0, mem_wdata_o = 0x1234_5678_0000_0000, lsu_done_o one cycle after gnt, reg_wen_o never 1.
- LD with rd = 0, rvalid 5 cycles after gnt -> lsu_done_o pulses, reg_wen_o stays 0; an ex_valid_i held high during the op is not accepted until IDLE.
- Assert lsu_rst_i asynchronously while in WAIT -> outputs cleared immediately, ex_ready_o = 1; a later mem_rvalid_i produces no write.
- With LSU_MISALIGN_EXC_EN: LW at 0x8000_0002 -> no mem_req_o; misalign_o = 1 and lsu_done_o = 1 at cycle 1.
